// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: state encodings, depth and pointer width shared by the FIFO controller.
package fifo_ctrl_pkg;
  localparam int AW = 3;
  localparam int FIFO_DEPTH = 8;
  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    WR_ERROR = 3'd3,
    READ     = 3'd4,
    RD_ERROR = 3'd5,
    RW       = 3'd6
  } state_t;
endpackage

// File: rtl/fifo_ctrl_ns.sv
// fifo_ctrl_ns: combinational next-state, pointer and flag decision for fifo_ctrl.
// FIFO_SIMUL_RW_EN lets simultaneous read and write requests both be serviced.
module fifo_ctrl_ns import fifo_ctrl_pkg::*; #(
  parameter int AW = fifo_ctrl_pkg::AW
) (
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [AW-1:0] head,
  input  logic [AW-1:0] tail,
  input  logic [AW:0]   count,
  output state_t        state_nxt,
  output logic [AW-1:0] head_nxt,
  output logic [AW-1:0] tail_nxt,
  output logic [AW:0]   count_nxt,
  output logic          do_wr,
  output logic          do_rd,
  output logic          wr_err_nxt,
  output logic          rd_err_nxt
);
  logic full, empty;
  assign full  = count[AW];
  assign empty = count == '0;
`ifdef FIFO_SIMUL_RW_EN
  assign do_wr      = wr_en & ~full;
  assign do_rd      = rd_en & ~empty;
  assign wr_err_nxt = wr_en & full;
  assign rd_err_nxt = rd_en & empty;
`else
  // Colliding requests are both dropped without any flag.
  assign do_wr      = wr_en & ~rd_en & ~full;
  assign do_rd      = rd_en & ~wr_en & ~empty;
  assign wr_err_nxt = wr_en & ~rd_en & full;
  assign rd_err_nxt = rd_en & ~wr_en & empty;
`endif
  assign head_nxt  = head + AW'(do_rd);
  assign tail_nxt  = tail + AW'(do_wr);
  assign count_nxt = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  assign state_nxt = (do_wr & do_rd) ? RW :
                     do_wr           ? WRITE :
                     do_rd           ? READ :
                     wr_err_nxt      ? WR_ERROR :
                     rd_err_nxt      ? RD_ERROR : NO_OP;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: head/tail/count sequencing for an 8-entry FIFO with registered ack/err flags.
// Build option FIFO_SIMUL_RW_EN enables simultaneous read+write servicing.
module fifo_ctrl import fifo_ctrl_pkg::*; #(
  parameter int AW = fifo_ctrl_pkg::AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          we,
  output logic [AW-1:0] wAddr,
  output logic          re,
  output logic [AW-1:0] rAddr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   data_count,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err
);
  state_t        state, state_nxt;
  logic [AW-1:0] head, tail, head_nxt, tail_nxt;
  logic [AW:0]   count, count_nxt;
  logic          do_wr, do_rd, wr_err_nxt, rd_err_nxt;
  fifo_ctrl_ns #(.AW(AW)) u_ns (
    .wr_en(wr_en), .rd_en(rd_en), .head(head), .tail(tail), .count(count),
    .state_nxt(state_nxt), .head_nxt(head_nxt), .tail_nxt(tail_nxt), .count_nxt(count_nxt),
    .do_wr(do_wr), .do_rd(do_rd), .wr_err_nxt(wr_err_nxt), .rd_err_nxt(rd_err_nxt)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= INIT;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      rd_ack <= 1'b0;
      rd_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      head   <= head_nxt;
      tail   <= tail_nxt;
      count  <= count_nxt;
      wr_ack <= do_wr;
      wr_err <= wr_err_nxt;
      rd_ack <= do_rd;
      rd_err <= rd_err_nxt;
    end
  end
  assign we         = do_wr & reset_n;
  assign re         = do_rd & reset_n;
  assign wAddr      = tail;
  assign rAddr      = head;
  assign full       = count[AW];
  assign empty      = count == '0;
  assign data_count = count;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed self-checking bench for fifo_ctrl, both FIFO_SIMUL_RW_EN builds.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;
  logic       clk = 1'b0, reset_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic       we, re, full, empty, wr_ack, wr_err, rd_ack, rd_err;
  logic [2:0] wAddr, rAddr;
  logic [3:0] data_count;
  int         errors = 0, checks = 0;
  fifo_ctrl dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en),
    .we(we), .wAddr(wAddr), .re(re), .rAddr(rAddr),
    .full(full), .empty(empty), .data_count(data_count),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // After return: registered outputs show the previous cycle, strobes the new request.
  task automatic next(input logic w, input logic r);
    @(posedge clk);
    #1;
    wr_en = w;
    rd_en = r;
    #1;
  endtask
  task automatic flags(input string tag, input logic [3:0] exp);
    chk(tag, {wr_ack, wr_err, rd_ack, rd_err}, exp);
  endtask
  initial begin
    int n;
    #2;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", data_count, 0);
    flags("rst_flags", 4'b0000);
    chk("rst_strobes", {we, re}, 0);
    chk("rst_addr", {wAddr, rAddr}, 0);
    #1 reset_n = 1'b1;
    chk("state_init", dut.state, INIT);
    next(0, 0);
    chk("state_noop", dut.state, NO_OP);
    for (int i = 0; i < 8; i++) begin
      next(1, 0);
      chk("fill_we", we, 1);
      chk("fill_waddr", wAddr, i);
      chk("fill_ack", wr_ack, i > 0);
    end
    next(0, 0);
    chk("fill_last_ack", wr_ack, 1);
    chk("full", full, 1);
    chk("full_count", data_count, 8);
    next(1, 0);
    chk("over_we", we, 0);
    next(0, 0);
    flags("over_flags", 4'b0100);
    chk("over_tail", wAddr, 0);
    chk("over_count", data_count, 8);
    for (int i = 0; i < 8; i++) begin
      next(0, 1);
      chk("drain_re", re, 1);
      chk("drain_raddr", rAddr, i);
      chk("drain_ack", rd_ack, i > 0);
    end
    next(0, 0);
    chk("drain_last_ack", rd_ack, 1);
    chk("empty", empty, 1);
    next(0, 1);
    chk("under_re", re, 0);
    next(0, 0);
    flags("under_flags", 4'b0001);
    chk("under_count", data_count, 0);
    repeat (6) next(1, 0);
    repeat (6) next(0, 1);
    for (int i = 0; i < 4; i++) begin
      next(1, 0);
      chk("wrap_waddr", wAddr, (6 + i) % 8);
    end
    next(0, 0);
    chk("wrap_count", data_count, 4);
    chk("wrap_raddr", rAddr, 6);
    next(0, 1);
    next(1, 1);
    chk("both_pre_count", data_count, 3);
`ifdef FIFO_SIMUL_RW_EN
    chk("rw_strobes", {we, re}, 2'b11);
    next(0, 0);
    flags("rw_flags", 4'b1010);
    chk("rw_count", data_count, 3);
    chk("rw_addr", {wAddr, rAddr}, {3'd3, 3'd0});
    chk("rw_state", dut.state, RW);
`else
    chk("both_strobes", {we, re}, 2'b00);
    next(0, 0);
    flags("both_flags", 4'b0000);
    chk("both_count", data_count, 3);
    chk("both_addr", {wAddr, rAddr}, {3'd2, 3'd7});
    chk("both_state", dut.state, NO_OP);
`endif
    repeat (3) next(0, 1);
    next(1, 1);
    chk("both_empty_pre", empty, 1);
`ifdef FIFO_SIMUL_RW_EN
    chk("rwe_strobes", {we, re}, 2'b10);
    next(0, 0);
    flags("rwe_flags", 4'b1001);
    chk("rwe_count", data_count, 1);
    n = 4;
`else
    chk("bothe_strobes", {we, re}, 2'b00);
    next(0, 0);
    flags("bothe_flags", 4'b0000);
    chk("bothe_count", data_count, 0);
    n = 5;
`endif
    repeat (n) next(1, 0);
    next(1, 0);
    chk("mid_count", data_count, 5);
    chk("mid_we", we, 1);
    reset_n = 1'b0;
    #1;
    chk("mr_we", we, 0);
    chk("mr_count", data_count, 0);
    chk("mr_empty", empty, 1);
    chk("mr_addr", {wAddr, rAddr}, 0);
    flags("mr_flags", 4'b0000);
    chk("mr_state", dut.state, INIT);
    #2 reset_n = 1'b1;
    #1;
    chk("post_we", we, 1);
    chk("post_waddr", wAddr, 0);
    next(0, 0);
    flags("post_flags", 4'b1000);
    chk("post_count", data_count, 1);
    chk("post_tail", wAddr, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
